unit_stream_aligner: RTL and testbench
======================================

# unit_stream_aligner

Parametrised successor of the 32-bit nibble aligner. It buffers a stream of fixed-width input beats, each carrying a variable number of valid units. It presents the oldest OUT_UNITS units, MSB-first, to a variable-length decoder, and drops whatever count of units the decoder consumes. New over the previous generation:
- unit size, beat width, window and buffer depth are parameters;
- the consume count is binary, not one-hot;
- input beats may be partial;
- frame end (`last`), flush and a protocol-error flag are supported.

## Interface
Parameters:
- UNIT_W, 4: bits per unit (4 = nibble).
- IN_UNITS, 8: units per input beat; power of 2, ≥2.
- OUT_UNITS, 8: units in the output window.
- BUF_UNITS, 16: buffer capacity in units; must be ≥ IN_UNITS and ≥ OUT_UNITS.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear; highest priority.
- in_vld  in  1  input beat valid.
- in_rdy  out  1  input beat accepted when in_vld & in_rdy.
- in_data  in  IN_UNITS*UNIT_W  beat payload; valid units are MSB-aligned.
- in_cnt  in  clog2(IN_UNITS)  number of valid units; 0 encodes IN_UNITS.
- in_last  in  1  beat ends the frame.
- out_data  out  OUT_UNITS*UNIT_W  oldest units, oldest in the MSBs; unfilled units read 0.
- out_avail  out  clog2(OUT_UNITS+1)  valid units in the window, min(level, OUT_UNITS).
- out_last  out  1  all remaining frame units are inside the window.
- cons_vld  in  1  consume request.
- cons_cnt  in  clog2(OUT_UNITS+1)  units to drop; 0 is a no-op.
- err  out  1  one-cycle pulse on an illegal consume.

## Operation
- State registers:
  - buffer, BUF_UNITS×UNIT_W;
  - level, 0..BUF_UNITS;
  - last_pend.
- out_data, out_avail and out_last are decoded from the registers only. They have no combinational path from any input.
- Effective consume:
  - cons_eff = cons_cnt when cons_vld & cons_cnt ≤ out_avail, else 0.
  - cons_vld & cons_cnt > out_avail is illegal: err = 1 on the next cycle, and nothing is consumed.
- in_rdy = !last_pend & (level − cons_eff + IN_UNITS ≤ BUF_UNITS). in_rdy has a combinational path from cons_vld and cons_cnt, as the previous generation had.
- Accepted beat:
  - Its n = (in_cnt==0 ? IN_UNITS : in_cnt) top units are appended directly after the units that remain after consumption.
  - Low units of the beat beyond n are discarded.
- Next level = level − cons_eff + n·accept.
- Buffer content shifts toward the MSB by cons_eff units. Vacated units are zero-filled.
- last_pend:
  - Set on acceptance of a beat with in_last.
  - Cleared when the level after consumption reaches 0 while last_pend is set.
- out_last = last_pend & (level ≤ OUT_UNITS).
- While last_pend is set, in_rdy = 0, so frames never mix in the buffer.
- Zero-unit frame end (n never 0, so no such case): not possible by encoding.
- flush = 1:
  - level → 0, last_pend → 0, buffer → 0, err → 0.
  - Same-cycle input and consume are ignored.
  - in_rdy = 0 during flush.
- Reset values:
  - level = 0, buffer = 0, last_pend = 0, err = 0.
  - Hence out_avail = 0, out_data = 0, out_last = 0.
  - in_rdy = 1 once reset_n deasserts.

## Timing
- Input-to-output latency: a beat accepted at edge k is visible in out_data/out_avail after edge k.
- Consume-to-update: a consume at edge k updates the window after edge k.
- Throughput: with BUF_UNITS ≥ IN_UNITS + OUT_UNITS, one full beat per cycle is sustained while the decoder consumes ≥ IN_UNITS per cycle.
- Simultaneous push and consume in one cycle is always legal, subject to in_rdy.
- Full boundary: with level = BUF_UNITS and no consume, in_rdy = 0. The same level with cons_cnt = IN_UNITS gives in_rdy = 1 in the same cycle.
- Empty boundary: level = 0 gives out_avail = 0. Any cons_vld with cons_cnt > 0 is then illegal and pulses err.
- reset_n asserted mid-frame clears all state immediately (asynchronous). No partial frame survives.

## Test plan
- Reset, then push beat 0x12345678 with in_cnt = 0 → next cycle out_data = 0x12345678, out_avail = 8, out_last = 0.
- Push 0xABCDEF01, then 0x23456789; consume 3, then 5, then 8 → windows read 0xDEF01234, then 0x23456789 (after consume 5 drains the first beat), then empty with out_avail = 0. No err.
- Partial beat: in_cnt = 3, data 0x9AB00000, with in_last → out_data = 0x9AB00000, out_avail = 3, out_last = 1, in_rdy = 0. Consume 3 → last_pend clears and in_rdy = 1.
- Fill to level 16 with the decoder idle → in_rdy = 0. Then cons_cnt = 8 with in_vld the same cycle → beat accepted and level stays 16.
- Illegal consume: out_avail = 2, cons_cnt = 5 → err = 1 for one cycle, window unchanged. Then flush → out_avail = 0 and err = 0.
- Assert reset_n low for one cycle mid-frame with level 12 and last_pend = 1 → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/unit_stream_aligner.sv
// Unit stream aligner: buffers partial input beats of UNIT_W-bit units and
// presents the oldest OUT_UNITS units MSB-first to a variable-length decoder.
module unit_stream_aligner #(
  parameter int UNIT_W    = 4,
  parameter int IN_UNITS  = 8,
  parameter int OUT_UNITS = 8,
  parameter int BUF_UNITS = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              flush,
  input  logic                              in_vld,
  output logic                              in_rdy,
  input  logic [IN_UNITS*UNIT_W-1:0]        in_data,
  input  logic [$clog2(IN_UNITS)-1:0]       in_cnt,
  input  logic                              in_last,
  output logic [OUT_UNITS*UNIT_W-1:0]       out_data,
  output logic [$clog2(OUT_UNITS+1)-1:0]    out_avail,
  output logic                              out_last,
  input  logic                              cons_vld,
  input  logic [$clog2(OUT_UNITS+1)-1:0]    cons_cnt,
  output logic                              err
);

  localparam int IN_W  = IN_UNITS * UNIT_W;
  localparam int OUT_W = OUT_UNITS * UNIT_W;
  localparam int BUF_W = BUF_UNITS * UNIT_W;
  localparam int CNT_W = $clog2(IN_UNITS);
  localparam int AV_W  = $clog2(OUT_UNITS + 1);
  localparam int LVL_W = $clog2(BUF_UNITS + 1);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             last_pend_q, last_pend_d;
  logic             err_q, err_d;

  logic             cons_legal_s;
  logic             accept_s;
  logic [LVL_W-1:0] cons_eff_s;
  logic [LVL_W-1:0] lvl_after_s;
  logic [LVL_W-1:0] n_s;
  logic [IN_W-1:0]  beat_mask_s;
  logic [BUF_W-1:0] beat_top_s;
  logic [BUF_W-1:0] beat_ext_s;
  logic [BUF_W-1:0] kept_s;

  // Window outputs decode the registers only; units past level are held at zero.
  assign out_data  = buf_q[BUF_W-1 -: OUT_W];
  assign out_avail = (level_q > LVL_W'(OUT_UNITS)) ? AV_W'(OUT_UNITS) : AV_W'(level_q);
  assign out_last  = last_pend_q && (level_q <= LVL_W'(OUT_UNITS));
  assign err       = err_q;

  // Consume legality, acceptance and the shifted/appended buffer image.
  always_comb begin
    cons_legal_s = (cons_cnt <= out_avail);
    if (cons_vld && cons_legal_s) begin
      cons_eff_s = LVL_W'(cons_cnt);
    end else begin
      cons_eff_s = {LVL_W{1'b0}};
    end
    lvl_after_s = level_q - cons_eff_s;
    in_rdy = !flush && !last_pend_q &&
             (({1'b0, lvl_after_s} + (LVL_W+1)'(IN_UNITS)) <= (LVL_W+1)'(BUF_UNITS));
    accept_s = in_vld && in_rdy;

    if (in_cnt == {CNT_W{1'b0}}) begin
      n_s = LVL_W'(IN_UNITS);
    end else begin
      n_s = LVL_W'(in_cnt);
    end

    // Keep only the top n units of the beat, then place it right behind the survivors.
    beat_mask_s = ~({IN_W{1'b1}} >> (32'(n_s) * 32'(UNIT_W)));
    beat_top_s  = {BUF_W{1'b0}};
    beat_top_s[BUF_W-1 -: IN_W] = in_data & beat_mask_s;
    beat_ext_s  = beat_top_s >> (32'(lvl_after_s) * 32'(UNIT_W));
    kept_s      = buf_q << (32'(cons_eff_s) * 32'(UNIT_W));
  end

  // Next-state selection; flush overrides any same-cycle push or consume.
  always_comb begin
    buf_d       = buf_q;
    level_d     = level_q;
    last_pend_d = last_pend_q;
    err_d       = 1'b0;
    if (flush) begin
      buf_d       = {BUF_W{1'b0}};
      level_d     = {LVL_W{1'b0}};
      last_pend_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      buf_d   = kept_s | (accept_s ? beat_ext_s : {BUF_W{1'b0}});
      level_d = lvl_after_s + (accept_s ? n_s : {LVL_W{1'b0}});
      err_d   = cons_vld && !cons_legal_s;
      if (accept_s && in_last) begin
        last_pend_d = 1'b1;
      end else if (last_pend_q && (lvl_after_s == {LVL_W{1'b0}})) begin
        last_pend_d = 1'b0;
      end else begin
        last_pend_d = last_pend_q;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q       <= {BUF_W{1'b0}};
      level_q     <= {LVL_W{1'b0}};
      last_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      level_q     <= level_d;
      last_pend_q <= last_pend_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_unit_stream_aligner.sv
// Table-driven bench for unit_stream_aligner (default parameters) with an
// expected-output queue and hand sequences for reset behaviour.
module tb_unit_stream_aligner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] in_data;
  logic [2:0]  in_cnt;
  logic        in_last;
  logic [31:0] out_data;
  logic [3:0]  out_avail;
  logic        out_last;
  logic        cons_vld;
  logic [3:0]  cons_cnt;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic [2:0]  c;
    logic        il;
    logic        cv;
    logic [3:0]  cc;
    logic        rdy;
    logic [31:0] od;
    logic [3:0]  oa;
    logic        ol;
    logic        er;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] od;
    logic [3:0]  oa;
    logic        ol;
    logic        er;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  unit_stream_aligner dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_avail (out_avail),
    .out_last  (out_last),
    .cons_vld  (cons_vld),
    .cons_cnt  (cons_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void add(input logic fl, input logic iv, input logic [31:0] d,
                              input logic [2:0] c, input logic il, input logic cv,
                              input logic [3:0] cc, input logic rdy, input logic [31:0] od,
                              input logic [3:0] oa, input logic ol, input logic er);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.c = c; v.il = il; v.cv = cv; v.cc = cc;
    v.rdy = rdy; v.od = od; v.oa = oa; v.ol = ol; v.er = er;
    tbl.push_back(v);
  endfunction

  task automatic idle_inputs();
    flush = 1'b0; in_vld = 1'b0; in_data = 32'h0; in_cnt = 3'd0;
    in_last = 1'b0; cons_vld = 1'b0; cons_cnt = 4'd0;
  endtask

  initial begin
    exp_t e;
    //  fl    iv    data          cnt   last  cv    cc     rdy   out_data      avail ol    err
    add(1'b0, 1'b1, 32'h12345678, 3'd0, 1'b0, 1'b0, 4'd0,  1'b1, 32'h12345678, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'd8,  1'b1, 32'h00000000, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'hABCDEF01, 3'd0, 1'b0, 1'b0, 4'd0,  1'b1, 32'hABCDEF01, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h23456789, 3'd0, 1'b0, 1'b0, 4'd0,  1'b1, 32'hABCDEF01, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'd3,  1'b0, 32'hDEF01234, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'd5,  1'b1, 32'h23456789, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'd8,  1'b1, 32'h00000000, 4'd0, 1'b0, 1'b0);
    // partial beat with frame end; low units must be discarded
    add(1'b0, 1'b1, 32'h9ABCDEF7, 3'd3, 1'b1, 1'b0, 4'd0,  1'b1, 32'h9AB00000, 4'd3, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 4'd0,  1'b0, 32'h9AB00000, 4'd3, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'd3,  1'b0, 32'h00000000, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b0, 4'd0,  1'b1, 32'h00000000, 4'd0, 1'b0, 1'b0);
    // fill to the full boundary, then push while consuming a beat's worth
    add(1'b0, 1'b1, 32'h11111111, 3'd0, 1'b0, 1'b0, 4'd0,  1'b1, 32'h11111111, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h22222222, 3'd0, 1'b0, 1'b0, 4'd0,  1'b1, 32'h11111111, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h33333333, 3'd0, 1'b0, 1'b0, 4'd0,  1'b0, 32'h11111111, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h33333333, 3'd0, 1'b0, 1'b1, 4'd8,  1'b1, 32'h22222222, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'd8,  1'b1, 32'h33333333, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'd6,  1'b1, 32'h33000000, 4'd2, 1'b0, 1'b0);
    // illegal consume leaves the window alone, then flush ignores push and consume
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'd5,  1'b1, 32'h33000000, 4'd2, 1'b0, 1'b1);
    add(1'b1, 1'b1, 32'h44444444, 3'd0, 1'b0, 1'b1, 4'd1,  1'b0, 32'h00000000, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b0, 4'd0,  1'b1, 32'h00000000, 4'd0, 1'b0, 1'b0);
    // empty boundary: any nonzero consume is illegal
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b1, 4'd1,  1'b1, 32'h00000000, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b0, 4'd0,  1'b1, 32'h00000000, 4'd0, 1'b0, 1'b0);
    // chained partial beats, append behind survivors of a same-cycle consume
    add(1'b0, 1'b1, 32'h5A5A5A5A, 3'd2, 1'b0, 1'b0, 4'd0,  1'b1, 32'h5A000000, 4'd2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'hC3C3C3C3, 3'd5, 1'b0, 1'b0, 4'd0,  1'b1, 32'h5AC3C3C0, 4'd7, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h12345678, 3'd0, 1'b0, 1'b1, 4'd1,  1'b1, 32'hAC3C3C12, 4'd8, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b0, 4'd0,  1'b0, 32'h00000000, 4'd0, 1'b0, 1'b0);
    // build level 12 with last pending for the mid-frame reset
    add(1'b0, 1'b1, 32'h11111111, 3'd0, 1'b0, 1'b0, 4'd0,  1'b1, 32'h11111111, 4'd8, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h2222ABCD, 3'd4, 1'b1, 1'b0, 4'd0,  1'b1, 32'h11111111, 4'd8, 1'b0, 1'b0);

    reset_n = 1'b0;
    idle_inputs();
    #1;
    chk("reset.out_data", out_data, 32'h0);
    chk("reset.out_avail", 32'(out_avail), 32'd0);
    chk("reset.out_last", 32'(out_last), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset.in_rdy", 32'(in_rdy), 32'd1);

    foreach (tbl[i]) begin
      @(negedge clk);
      flush = tbl[i].fl; in_vld = tbl[i].iv; in_data = tbl[i].d; in_cnt = tbl[i].c;
      in_last = tbl[i].il; cons_vld = tbl[i].cv; cons_cnt = tbl[i].cc;
      #1;
      chk($sformatf("v%0d.in_rdy", i), 32'(in_rdy), 32'(tbl[i].rdy));
      e.idx = i; e.od = tbl[i].od; e.oa = tbl[i].oa; e.ol = tbl[i].ol; e.er = tbl[i].er;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d.out_data", e.idx), out_data, e.od);
      chk($sformatf("v%0d.out_avail", e.idx), 32'(out_avail), 32'(e.oa));
      chk($sformatf("v%0d.out_last", e.idx), 32'(out_last), 32'(e.ol));
      chk($sformatf("v%0d.err", e.idx), 32'(err), 32'(e.er));
    end

    // mid-frame asynchronous reset: level 12 with last pending
    @(negedge clk);
    idle_inputs();
    #1;
    chk("midframe.in_rdy_blocked", 32'(in_rdy), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset.out_data", out_data, 32'h0);
    chk("areset.out_avail", 32'(out_avail), 32'd0);
    chk("areset.out_last", 32'(out_last), 32'd0);
    chk("areset.err", 32'(err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("areset.in_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1;
    chk("areset.avail_after_edge", 32'(out_avail), 32'd0);
    chk("areset.last_after_edge", 32'(out_last), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
